// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic arithmetic datapath: default operand widths
// and the divider FSM state encoding.
package vedic_pkg;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/vedic_seq_divider_if.sv
// Operand/result channel of the sequential divider.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and data stable until that edge, ready never depends on valid.
interface vedic_seq_divider_if
  import vedic_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/vedic_div_step.sv
// One combinational restoring-division stage: shift in the next dividend bit,
// subtract the divisor when it fits, and emit the resulting quotient bit.
module vedic_div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W-1:0] r_in,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] r_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] t;

  assign t     = {r_in, din};
  assign q_bit = (t >= {1'b0, divisor});
  // When the divisor fits, the true difference is below divisor, so the
  // modulo-2^DIVISOR_W subtraction of the low bits is exact.
  assign r_out = q_bit ? (t[DIVISOR_W-1:0] - divisor) : t[DIVISOR_W-1:0];

endmodule

// File: rtl/vedic_seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, with valid/ready
// handshakes on the operand and result sides.
module vedic_seq_divider
  import vedic_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                clk,
  input  logic                rst,
  vedic_seq_divider_if.slave  bus,
  output state_t              state_dbg
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  state_t                state;
  logic [DIVIDEND_W-1:0] q_sh;
  // Restored partial remainder is always below the divisor, so its extra
  // top bit is identically zero and is not stored.
  logic [DIVISOR_W-1:0]  r_reg;
  logic [DIVISOR_W-1:0]  divisor_reg;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] quotient_reg;
  logic [DIVISOR_W-1:0]  remainder_reg;
  logic                  dbz_reg;
  logic                  out_valid_reg;

  logic [DIVISOR_W-1:0]  r_next;
  logic                  q_bit;
  logic [DIVIDEND_W-1:0] q_next;

  vedic_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .r_in    (r_reg),
    .din     (q_sh[DIVIDEND_W-1]),
    .divisor (divisor_reg),
    .r_out   (r_next),
    .q_bit   (q_bit)
  );

  assign q_next = {q_sh[DIVIDEND_W-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      q_sh          <= '0;
      r_reg         <= '0;
      divisor_reg   <= '0;
      cnt           <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.divisor != '0) begin
              q_sh        <= bus.dividend;
              r_reg       <= '0;
              divisor_reg <= bus.divisor;
              cnt         <= CNT_W'(DIVIDEND_W - 1);
              state       <= CALC;
            end else begin
              quotient_reg  <= '1;
              remainder_reg <= '0;
              dbz_reg       <= 1'b1;
              out_valid_reg <= 1'b1;
              state         <= DONE;
            end
          end
        end
        CALC: begin
          q_sh  <= q_next;
          r_reg <= r_next;
          if (cnt == '0) begin
            quotient_reg  <= q_next;
            remainder_reg <= r_next;
            dbz_reg       <= 1'b0;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;
  assign state_dbg       = state;

endmodule

// File: tb/tb_vedic_seq_divider.sv
// Directed and exhaustive bench for vedic_seq_divider: scoreboard of expected
// results, latency/handshake checks, back-pressure and mid-operation reset.
module tb_vedic_seq_divider;
  import vedic_pkg::*;

  localparam int DW    = 8;
  localparam int VW    = 4;
  localparam int EXP_W = DW + VW + DW + VW + 1;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state_dbg;
  int     checks = 0;
  int     errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  vedic_seq_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus ();

  vedic_seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Urdhva-tiryakbhyam (vertical and crosswise) 4x4 product, column by column.
  function automatic logic [7:0] vedic_mul4(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    int s;
    int carry;
    p = '0;
    carry = 0;
    for (int k = 0; k < 7; k++) begin
      s = carry;
      for (int i = 0; i < 4; i++)
        if (k - i >= 0 && k - i < 4) s += int'(a[i] & b[k-i]);
      p[k]  = s[0];
      carry = s >> 1;
    end
    p[7] = carry[0];
    return p;
  endfunction

  function automatic logic [EXP_W-1:0] ref_model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    if (b == '0) return {a, b, {DW{1'b1}}, {VW{1'b0}}, 1'b1};
    return {a, b, DW'(a / b), VW'(a % b), 1'b0};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_quotient", 32'(bus.quotient), 0);
    check("rst_remainder", 32'(bus.remainder), 0);
    check("rst_dbz", 32'(bus.div_by_zero), 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // driver: present one operand pair and hold it for exactly the accepting edge
  task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("send_in_ready", 32'(bus.in_ready), 1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = DW'($urandom);
    bus.divisor  = VW'($urandom);
    exp_q.push_back(ref_model(a, b));
  endtask

  // monitor/scoreboard: wait for the result, compare, stall, then take it
  task automatic collect(input int stall);
    logic [EXP_W-1:0] e;
    logic [DW-1:0] a, q_obs;
    logic [VW-1:0] b, r_obs;
    logic          z_obs;
    int cyc;
    cyc = 0;
    bus.out_ready = 1'b0;
    while (!bus.out_valid && cyc < 40) begin
      check("busy_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("out_valid_seen", 32'(bus.out_valid), 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'(exp_q.size()), 1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    a = e[EXP_W-1 -: DW];
    b = e[EXP_W-DW-1 -: VW];
    check("latency", 32'(cyc), e[0] ? 0 : DW);
    check("quotient", 32'(bus.quotient), 32'(e[VW+DW : VW+1]));
    check("remainder", 32'(bus.remainder), 32'(e[VW:1]));
    check("div_by_zero", 32'(bus.div_by_zero), 32'(e[0]));
    q_obs = bus.quotient;
    r_obs = bus.remainder;
    z_obs = bus.div_by_zero;
    if (!e[0]) begin
      check("rem_lt_divisor", 32'(r_obs < b), 1);
      if (q_obs < 16)
        check("vedic_invariant", 32'(vedic_mul4(q_obs[3:0], b) + 8'(r_obs)), 32'(a));
    end
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = DW'($urandom);
      bus.divisor  = VW'($urandom_range(1, 15));
      @(posedge clk);
      #1;
      check("stall_out_valid", 32'(bus.out_valid), 1);
      check("stall_in_ready", 32'(bus.in_ready), 0);
      check("stall_quotient", 32'(bus.quotient), 32'(q_obs));
      check("stall_remainder", 32'(bus.remainder), 32'(r_obs));
      check("stall_dbz", 32'(bus.div_by_zero), 32'(z_obs));
    end
    bus.in_valid  = 1'b1;
    bus.dividend  = DW'($urandom);
    bus.divisor   = VW'($urandom_range(1, 15));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("take_out_valid", 32'(bus.out_valid), 0);
    check("take_in_ready", 32'(bus.in_ready), 1);
    check("take_keep_quotient", 32'(bus.quotient), 32'(q_obs));
    check("take_keep_remainder", 32'(bus.remainder), 32'(r_obs));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    do_reset();

    send(8'd200, 4'd7);  collect(0);
    send(8'd255, 4'd1);  collect(1);
    send(8'd5,   4'd9);  collect(0);
    send(8'd15,  4'd15); collect(0);
    send(8'd0,   4'd3);  collect(0);
    send(8'd100, 4'd0);  collect(0);
    send(8'd100, 4'd3);  collect(0);
    send(8'd200, 4'd7);  collect(5);

    // out_ready pulses while idle must have no effect
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("idle_out_ready_in_ready", 32'(bus.in_ready), 1);
    check("idle_out_ready_out_valid", 32'(bus.out_valid), 0);

    // reset in the middle of a calculation
    send(8'd200, 4'd7);
    repeat (3) @(posedge clk);
    #1;
    check("mid_calc_state", 32'(state_dbg), 32'(ST_CALC));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    check("midrst_quotient", 32'(bus.quotient), 0);
    check("midrst_remainder", 32'(bus.remainder), 0);
    check("midrst_dbz", 32'(bus.div_by_zero), 0);
    send(8'd9, 4'd2); collect(0);

    // exhaustive sweep with random result stalls
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++) begin
        send(DW'(a), VW'(b));
        collect($urandom_range(0, 2));
      end

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
